switch_repeater: RTL and testbench

SWITCH_REPEATER -- requirements
Module: switch_repeater

---
 rtl/switch_repeater_pkg.sv | 23 ++
 rtl/switch_repeater_if.sv | 27 ++
 rtl/switch_debounce.sv | 54 +++++
 rtl/switch_repeater.sv | 114 +++++++++++
 tb/tb_switch_repeater.sv | 124 ++++++++++++
 5 files changed

// File: rtl/switch_repeater_pkg.sv
// Shared definitions for push-button front-ends.
//   rep_state_t              : auto-repeat FSM state encoding (IDLE=0, DELAY=1, REPEAT=2)
//   DEFAULT_DEBOUNCE_CYCLES  : default stable cycles needed to accept a new level
//   DEFAULT_REPEAT_DELAY     : default cycles from press pulse to first repeat
//   DEFAULT_REPEAT_PERIOD    : default cycles between repeat pulses
//   max_u()                  : larger of two unsigned values (for counter sizing)
package switch_repeater_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 65536;
    localparam int unsigned DEFAULT_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEFAULT_REPEAT_PERIOD   = 6250000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/switch_repeater_if.sv
// Button-side signal bundle for switch_repeater.
//   switch_input : raw asynchronous push-button, active high
//   level        : debounced switch state
//   trans_up     : one-cycle pulse on accepted press and each auto-repeat
//   trans_dn     : one-cycle pulse on accepted release
// Modports: master = user of the button (drives switch_input),
//           slave  = switch_repeater (drives the decoded outputs).
interface switch_repeater_if;
    logic switch_input;
    logic level;
    logic trans_up;
    logic trans_dn;

    modport master (
        output switch_input,
        input  level,
        input  trans_up,
        input  trans_dn
    );

    modport slave (
        input  switch_input,
        output level,
        output trans_up,
        output trans_dn
    );
endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus debounce counter for one push-button.
//   CLK          : system clock, rising edge
//   RST          : synchronous active-high reset
//   switch_input : raw asynchronous button input
//   level        : registered debounced state
//   rise / fall  : single-cycle strobes, high in the cycle before level
//                  goes 1 / 0, so the parent can register its edge pulses
//                  on the same clock edge that updates level
module switch_debounce
    import switch_repeater_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic switch_input,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_meta;
    logic          synced;
    logic [CW-1:0] cnt;
    logic          hit;

    // Count reaches DEBOUNCE_CYCLES on this edge: accept the new level.
    assign hit  = (synced != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise = hit && !level;
    assign fall = hit &&  level;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_meta <= 1'b0;
            synced    <= 1'b0;
            cnt       <= '0;
            level     <= 1'b0;
        end else begin
            sync_meta <= switch_input;
            synced    <= sync_meta;
            if (synced == level) begin
                cnt <= '0;
            end else if (hit) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_repeater.sv
// Debounced push-button with optional auto-repeat.
//   CLK : system clock, rising edge
//   RST : synchronous active-high reset
//   sw  : switch_repeater_if.slave (switch_input in; level, trans_up,
//         trans_dn out, all registered)
// Macro SWITCH_REPEATER_AUTOREPEAT_EN: when defined, a held button emits
// trans_up again REPEAT_DELAY cycles after the press and then every
// REPEAT_PERIOD cycles. When undefined, trans_up pulses once per press and
// the repeat parameters are ignored.
module switch_repeater
    import switch_repeater_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input logic          CLK,
    input logic          RST,
    switch_repeater_if.slave sw
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("switch_repeater: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic level;
    logic rise;
    logic fall;
    logic trans_up_q;
    logic trans_dn_q;

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK         (CLK),
        .RST         (RST),
        .switch_input(sw.switch_input),
        .level       (level),
        .rise        (rise),
        .fall        (fall)
    );

`ifdef SWITCH_REPEATER_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    rep_state_t    state;
    logic [RW-1:0] rcnt;

    // rcnt starts at 0 on the press edge, so the first repeat lands exactly
    // REPEAT_DELAY cycles after the press pulse. A release (fall) overrides
    // any repeat due on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            rcnt       <= '0;
            trans_up_q <= 1'b0;
            trans_dn_q <= 1'b0;
        end else begin
            trans_up_q <= 1'b0;
            trans_dn_q <= fall;
            if (fall) begin
                state <= IDLE;
                rcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            trans_up_q <= 1'b1;
                            state      <= DELAY;
                            rcnt       <= '0;
                        end
                    end
                    DELAY: begin
                        if (rcnt == RW'(REPEAT_DELAY - 1)) begin
                            trans_up_q <= 1'b1;
                            state      <= REPEAT;
                            rcnt       <= '0;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rcnt == RW'(REPEAT_PERIOD - 1)) begin
                            trans_up_q <= 1'b1;
                            rcnt       <= '0;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end
                endcase
            end
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (RST) begin
            trans_up_q <= 1'b0;
            trans_dn_q <= 1'b0;
        end else begin
            trans_up_q <= rise;
            trans_dn_q <= fall;
        end
    end
`endif

    assign sw.level    = level;
    assign sw.trans_up = trans_up_q;
    assign sw.trans_dn = trans_dn_q;

endmodule

// File: tb/tb_switch_repeater.sv
// Directed bench for switch_repeater with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Expectations follow the build: repeat
// pulses are expected only when SWITCH_REPEATER_AUTOREPEAT_EN is defined.
// Cycle k is observed 1 time unit after the k-th rising edge; inputs set
// in cycle k are first sampled by edge k+1.
module tb_switch_repeater;

`ifdef SWITCH_REPEATER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    switch_repeater_if sw_if ();

    switch_repeater #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .sw (sw_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input int k, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic check_cycle(input string scen, input int k,
                               input logic e_level, input logic e_up, input logic e_dn);
        check({scen, ".level"},    k, sw_if.level,    e_level);
        check({scen, ".trans_up"}, k, sw_if.trans_up, e_up);
        check({scen, ".trans_dn"}, k, sw_if.trans_dn, e_dn);
    endtask

    // Two reset edges with the switch low; leaves the bench at cycle 0 of
    // the next scenario with RST already deasserted for edge 1.
    task automatic do_reset(input string scen);
        RST = 1'b1;
        sw_if.switch_input = 1'b0;
        step();
        check_cycle({scen, ".reset"}, 0, 1'b0, 1'b0, 1'b0);
        step();
        RST = 1'b0;
    endtask

    initial begin
        logic el, eu, ed;
        checks = 0;
        errors = 0;
        RST = 1'b1;
        sw_if.switch_input = 1'b0;

        // A: clean press, reset held over cycles 20-21 with the switch down.
        do_reset("press");
        for (int k = 0; k <= 45; k++) begin
            el = ((k >= 6) && (k <= 20)) || (k >= 28);
            eu = (k == 6) || (k == 28) ||
                 (AR && (((k >= 16) && (k <= 20) && ((k - 16) % 3 == 0)) ||
                         ((k >= 38) && ((k - 38) % 3 == 0))));
            ed = 1'b0;
            check_cycle("press", k, el, eu, ed);
            if (k == 0)  sw_if.switch_input = 1'b1;
            if (k == 20) RST = 1'b1;
            if (k == 22) RST = 1'b0;
            step();
        end

        // B: hold 50 cycles then release; single trans_dn 6 cycles later.
        do_reset("hold");
        for (int k = 0; k <= 62; k++) begin
            el = (k >= 6) && (k < 56);
            eu = (k == 6) || (AR && (k >= 16) && (k < 56) && ((k - 16) % 3 == 0));
            ed = (k == 56);
            check_cycle("hold", k, el, eu, ed);
            if (k == 0)  sw_if.switch_input = 1'b1;
            if (k == 50) sw_if.switch_input = 1'b0;
            step();
        end

        // C: release during DELAY; release wins on the edge a repeat was due.
        do_reset("early_rel");
        for (int k = 0; k <= 30; k++) begin
            el = (k >= 6) && (k < 16);
            eu = (k == 6);
            ed = (k == 16);
            check_cycle("early_rel", k, el, eu, ed);
            if (k == 0)  sw_if.switch_input = 1'b1;
            if (k == 10) sw_if.switch_input = 1'b0;
            step();
        end

        // D: 3-cycle glitch never reaches the debounce count.
        do_reset("glitch");
        for (int k = 0; k <= 14; k++) begin
            check_cycle("glitch", k, 1'b0, 1'b0, 1'b0);
            if (k == 0) sw_if.switch_input = 1'b1;
            if (k == 3) sw_if.switch_input = 1'b0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
